// File: rtl/rv32i_pkg.sv
// rv32i_pkg -- shared definitions for the RV32I front end.
// Contents: fetch FSM state enum, NOP encoding, default reset PC and the
// sequential-PC helper used by the fetch unit.
package rv32i_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sequential PC; the 32-bit add wraps 32'hFFFF_FFFC to 32'h0000_0000.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf -- one-entry buffer that parks an instruction word (and its
// PC) returned by memory while decode is stalled.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push            capture data_in/pc_in (entry becomes full)
//   pop             release the entry (entry becomes empty)
//   clear           discard the entry; wins over push and pop
//   data_in, pc_in  word and its PC to capture
//   full            entry holds a word
//   data_out,pc_out the parked word and its PC
module fetch_hold_buf
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  logic [31:0] data_in,
  input  logic [31:0] pc_in,
  output logic        full,
  output logic [31:0] data_out,
  output logic [31:0] pc_out
);

  logic        full_q;
  logic [31:0] data_q;
  logic [31:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= NOP_INSTR;
      pc_q   <= 32'h0000_0000;
    end else if (clear) begin
      full_q <= 1'b0;
    end else if (push) begin
      full_q <= 1'b1;
      data_q <= data_in;
      pc_q   <= pc_in;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

  assign full     = full_q;
  assign data_out = data_q;
  assign pc_out   = pc_q;

endmodule

// File: rtl/fetch.sv
// fetch -- instruction fetch unit with a single outstanding memory request.
//
// state | meaning
// ------+------------------------------------------------------------------
// REQ   | request fetch_pc (imem_req=1 unless the hold buffer is full)
// WAIT  | one request granted, waiting for imem_rvalid; kill drops the word
// HALT  | misaligned redirect seen; no requests until rst
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    decode cannot accept a word this cycle
//   redirect, redirect_addr  resolved control transfer and its target
//   imem_req, imem_addr      request to instruction memory
//   imem_gnt                 request accepted this cycle
//   imem_rvalid, imem_rdata  response (at least one cycle after grant)
//   instruction, pc_address  word and PC presented to decode
//   valid                    instruction/pc_address are live
//   misalign                 sticky misaligned-redirect flag
// Build option: FETCH_MISALIGN_CHECK_EN enables misaligned-target detection
// (HALT + misalign). Without it the target's low two bits are forced to 0.
module fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_address,
  output logic        valid,
  output logic        misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         kill_q, kill_d;
  logic         misalign_q, misalign_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_addr_q, pc_addr_d;

  logic         buf_push, buf_pop, buf_clear, buf_full;
  logic [31:0]  buf_data, buf_pc;

  logic [31:0]  redir_tgt;
  logic         redir_bad;
  logic         accept;
  logic         deliver;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_tgt = redirect_addr;
  assign redir_bad = redirect && (redirect_addr[1:0] != 2'b00);
`else
  assign redir_tgt = redirect_addr & 32'hFFFF_FFFC;
  assign redir_bad = 1'b0;
`endif

  // No new request while a parked word waits for decode.
  assign imem_req  = (state_q == ST_REQ) && !buf_full && !rst;
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_gnt;

  fetch_hold_buf u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (buf_push),
    .pop      (buf_pop),
    .clear    (buf_clear),
    .data_in  (imem_rdata),
    .pc_in    (fetch_pc_q),
    .full     (buf_full),
    .data_out (buf_data),
    .pc_out   (buf_pc)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    misalign_d = misalign_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_addr_d  = pc_addr_q;
    buf_push   = 1'b0;
    buf_pop    = 1'b0;
    buf_clear  = 1'b0;
    deliver    = 1'b0;

    case (state_q)
      ST_REQ: begin
        if (accept) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_d = ST_REQ;
          kill_d  = 1'b0;
          // After a kill, fetch_pc already holds the redirect target.
          if (!kill_q) begin
            fetch_pc_d = pc_next(fetch_pc_q);
            deliver    = 1'b1;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase

    // Output stage: stall freezes the outputs; a word returned under stall
    // is parked and drained on the first unstalled cycle.
    if (stall) begin
      if (deliver) buf_push = 1'b1;
    end else if (deliver) begin
      valid_d   = 1'b1;
      instr_d   = imem_rdata;
      pc_addr_d = fetch_pc_q;
    end else if (buf_full) begin
      valid_d   = 1'b1;
      instr_d   = buf_data;
      pc_addr_d = buf_pc;
      buf_pop   = 1'b1;
    end else begin
      valid_d = 1'b0;
    end

    // Redirect overrides stall and any word delivered in the same cycle.
    if (redirect && state_q != ST_HALT) begin
      valid_d    = 1'b0;
      buf_clear  = 1'b1;
      buf_push   = 1'b0;
      buf_pop    = 1'b0;
      fetch_pc_d = redir_tgt;
      if (state_q == ST_REQ) begin
        // A grant in this cycle leaves a wrong-path word in flight.
        state_d = accept ? ST_WAIT : ST_REQ;
        kill_d  = accept;
      end else begin
        state_d = imem_rvalid ? ST_REQ : ST_WAIT;
        kill_d  = !imem_rvalid;
      end
      if (redir_bad) begin
        state_d    = ST_HALT;
        misalign_d = 1'b1;
        kill_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_REQ;
      fetch_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
      misalign_q <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_addr_q  <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
      misalign_q <= misalign_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_addr_q  <= pc_addr_d;
    end
  end

  assign instruction = instr_q;
  assign pc_address  = pc_addr_q;
  assign valid       = valid_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_fetch.sv
// tb_fetch -- directed, table-driven bench for the fetch unit. Each table row
// is one clock cycle: inputs for that cycle and the outputs expected in it.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_gnt, imem_rvalid;
  logic [31:0] redirect_addr, imem_rdata;
  logic        imem_req, valid, misalign;
  logic [31:0] imem_addr, instruction, pc_address;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .pc_address    (pc_address),
    .valid         (valid),
    .misalign      (misalign)
  );

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rda;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rda,
                              input logic gnt, input logic rv, input logic [31:0] rdata,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_vld, input logic [31:0] e_instr,
                              input logic [31:0] e_pc, input logic e_mis);
    vec_t v;
    v.st = st; v.rd = rd; v.rda = rda; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
    v.e_instr = e_instr; v.e_pc = e_pc; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rda,
                       input logic gnt, input logic rv, input logic [31:0] rdata);
    stall = st; redirect = rd; redirect_addr = rda;
    imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // word values returned by the memory model
    vecs.push_back(mk(0,0,0,           1,0,0,            1,32'h0,  0,0,0,0));
    vecs.push_back(mk(0,0,0,           0,1,32'hA000_0000, 0,0,     0,0,0,0));
    vecs.push_back(mk(0,0,0,           1,0,0,            1,32'h4,  1,32'hA000_0000,32'h0,0));
    vecs.push_back(mk(0,0,0,           0,1,32'hA000_0004, 0,0,     0,0,0,0));
    vecs.push_back(mk(0,0,0,           1,0,0,            1,32'h8,  1,32'hA000_0004,32'h4,0));
    vecs.push_back(mk(0,0,0,           0,1,32'hA000_0008, 0,0,     0,0,0,0));
    // stall for three cycles while the next word returns
    vecs.push_back(mk(1,0,0,           1,0,0,            1,32'hC,  1,32'hA000_0008,32'h8,0));
    vecs.push_back(mk(1,0,0,           0,1,32'h0050_0093, 0,0,     1,32'hA000_0008,32'h8,0));
    vecs.push_back(mk(1,0,0,           0,0,0,            0,0,      1,32'hA000_0008,32'h8,0));
    vecs.push_back(mk(0,0,0,           0,0,0,            0,0,      1,32'hA000_0008,32'h8,0));
    vecs.push_back(mk(0,0,0,           1,0,0,            1,32'h10, 1,32'h0050_0093,32'hC,0));
    // redirect while waiting: the pending word is dropped
    vecs.push_back(mk(0,1,32'h100,     0,0,0,            0,0,      0,0,0,0));
    vecs.push_back(mk(0,0,0,           0,1,32'hDEAD_BEEF, 0,0,     0,0,0,0));
    vecs.push_back(mk(0,0,0,           1,0,0,            1,32'h100,0,0,0,0));
    vecs.push_back(mk(0,0,0,           0,1,32'hB000_0000, 0,0,     0,0,0,0));
    // park a word under stall, then redirect+stall together empties it
    vecs.push_back(mk(1,0,0,           1,0,0,            1,32'h104,1,32'hB000_0000,32'h100,0));
    vecs.push_back(mk(1,0,0,           0,1,32'hB000_0004, 0,0,     1,32'hB000_0000,32'h100,0));
    vecs.push_back(mk(1,1,32'h200,     0,0,0,            0,0,      1,32'hB000_0000,32'h100,0));
    vecs.push_back(mk(1,0,0,           1,0,0,            1,32'h200,0,0,0,0));
    vecs.push_back(mk(0,0,0,           0,1,32'hC000_0000, 0,0,     0,0,0,0));
    vecs.push_back(mk(0,0,0,           0,0,0,            1,32'h204,1,32'hC000_0000,32'h200,0));
    // redirect in REQ without grant, then PC wrap at the top of memory
    vecs.push_back(mk(0,1,32'hFFFF_FFFC,0,0,0,           1,32'h204,0,0,0,0));
    vecs.push_back(mk(0,0,0,           1,0,0,            1,32'hFFFF_FFFC,0,0,0,0));
    vecs.push_back(mk(0,0,0,           0,1,32'hD000_0000, 0,0,     0,0,0,0));
    vecs.push_back(mk(0,0,0,           1,0,0,            1,32'h0,  1,32'hD000_0000,32'hFFFF_FFFC,0));
    // redirect together with rvalid, then redirect together with a grant
    vecs.push_back(mk(0,1,32'h300,     0,1,32'hE000_0000, 0,0,     0,0,0,0));
    vecs.push_back(mk(0,1,32'h400,     1,0,0,            1,32'h300,0,0,0,0));
    vecs.push_back(mk(0,0,0,           0,1,32'h0000_0BAD, 0,0,     0,0,0,0));
    vecs.push_back(mk(0,0,0,           1,0,0,            1,32'h400,0,0,0,0));
    vecs.push_back(mk(0,0,0,           0,1,32'hF000_0000, 0,0,     0,0,0,0));
    vecs.push_back(mk(0,0,0,           0,0,0,            1,32'h404,1,32'hF000_0000,32'h400,0));
    // misaligned redirect target
    vecs.push_back(mk(0,1,32'h102,     0,0,0,            1,32'h404,0,0,0,0));
`ifdef FETCH_MISALIGN_CHECK_EN
    vecs.push_back(mk(0,0,0,           1,0,0,            0,0,      0,0,0,1));
    vecs.push_back(mk(0,0,0,           0,1,32'h0000_0055, 0,0,     0,0,0,1));
    vecs.push_back(mk(0,0,0,           1,0,0,            0,0,      0,0,0,1));
    vecs.push_back(mk(0,0,0,           0,0,0,            0,0,      0,0,0,1));
`else
    vecs.push_back(mk(0,0,0,           1,0,0,            1,32'h100,0,0,0,0));
    vecs.push_back(mk(0,0,0,           0,1,32'h0000_0055, 0,0,     0,0,0,0));
    vecs.push_back(mk(0,0,0,           1,0,0,            1,32'h104,1,32'h0000_0055,32'h100,0));
    vecs.push_back(mk(0,0,0,           0,0,0,            0,0,      0,0,0,0));
`endif

    // reset
    rst = 1'b1;
    drive(0,0,0,0,0,0);
    repeat (3) @(negedge clk);
    chk("rst_req",   0, {31'b0, imem_req}, 32'h0);
    chk("rst_valid", 0, {31'b0, valid},    32'h0);
    chk("rst_instr", 0, instruction,       32'h0000_0013);
    chk("rst_pc",    0, pc_address,        32'h0);
    chk("rst_mis",   0, {31'b0, misalign}, 32'h0);
    rst = 1'b0;
    @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].st, vecs[i].rd, vecs[i].rda, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
      #1;
      chk("imem_req", i, {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req) chk("imem_addr", i, imem_addr, vecs[i].e_addr);
      chk("valid", i, {31'b0, valid}, {31'b0, vecs[i].e_vld});
      if (vecs[i].e_vld) begin
        chk("instruction", i, instruction, vecs[i].e_instr);
        chk("pc_address",  i, pc_address,  vecs[i].e_pc);
      end
      chk("misalign", i, {31'b0, misalign}, {31'b0, vecs[i].e_mis});
    end

    // reset during an outstanding request; the late response must be ignored
    @(negedge clk);
    drive(0,0,0,1,0,0);
    @(negedge clk);
    rst = 1'b1;
    drive(0,0,0,0,0,0);
    @(negedge clk);
    chk("rst2_req", 100, {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    chk("rst2_mis",   101, {31'b0, misalign}, 32'h0);
    chk("rst2_valid", 101, {31'b0, valid},    32'h0);
    chk("rst2_instr", 101, instruction,       32'h0000_0013);
    rst = 1'b0;
    drive(0,0,0,0,1,32'h0000_0077);
    #1;
    chk("post_rst_req",  102, {31'b0, imem_req}, 32'h1);
    chk("post_rst_addr", 102, imem_addr,         32'h0);
    @(negedge clk);
    drive(0,0,0,0,0,0);
    #1;
    chk("stale_valid", 103, {31'b0, valid},    32'h0);
    chk("stale_req",   103, {31'b0, imem_req}, 32'h1);
    chk("stale_addr",  103, imem_addr,         32'h0);
    @(negedge clk);
    drive(0,0,0,1,0,0);
    @(negedge clk);
    drive(0,0,0,0,1,32'h0000_0088);
    @(negedge clk);
    drive(0,0,0,0,0,0);
    #1;
    chk("fresh_valid", 104, {31'b0, valid}, 32'h1);
    chk("fresh_instr", 104, instruction,    32'h0000_0088);
    chk("fresh_pc",    104, pc_address,     32'h0);
    chk("fresh_addr",  104, imem_addr,      32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
